// File: rtl/ycbcr2rgb_block_if.sv
// Block-level bus for the inverse colour converter: start/busy/done handshake
// plus the packed 64-sample Y/Cb/Cr inputs and the packed 64-pixel R/G/B outputs.
interface ycbcr2rgb_block_if #(
   parameter int unsigned FIXED_POINT_LENGTH = 32
);
   localparam int unsigned NPIX = 64;

   logic                               start;
   logic [FIXED_POINT_LENGTH*NPIX-1:0] y_all;
   logic [FIXED_POINT_LENGTH*NPIX-1:0] cb_all;
   logic [FIXED_POINT_LENGTH*NPIX-1:0] cr_all;
   logic [8*NPIX-1:0]                  r_all;
   logic [8*NPIX-1:0]                  g_all;
   logic [8*NPIX-1:0]                  b_all;
   logic                               busy;
   logic                               done;

   modport master (
      output start, y_all, cb_all, cr_all,
      input  r_all, g_all, b_all, busy, done
   );

   modport slave (
      input  start, y_all, cb_all, cr_all,
      output r_all, g_all, b_all, busy, done
   );
endinterface

// File: rtl/ycbcr2rgb_block.sv
// Inverse YCbCr->RGB converter for one 8x8 block: captures 64 fixed-point samples,
// streams them one per cycle through a 3-stage multiply/sum/round-clamp pipeline.
module ycbcr2rgb_block #(
   parameter int unsigned FIXED_POINT_LENGTH = 32,
   parameter int unsigned FRAC_BITS          = 16
) (
   input  logic           clk,
   input  logic           rst,
   ycbcr2rgb_block_if.slave bus
);
   localparam int unsigned FPL    = FIXED_POINT_LENGTH;
   localparam int unsigned W      = FPL + 20;
   localparam int unsigned NPIX   = 64;
   localparam int unsigned KSHIFT = 16;

   localparam logic signed [W-1:0] OFFSET = W'(longint'(128) <<< FRAC_BITS);
   localparam logic signed [W-1:0] HALF   = W'(longint'(1) <<< (FRAC_BITS - 1));
   localparam logic signed [W-1:0] K_R_CR = W'(91881);
   localparam logic signed [W-1:0] K_G_CB = W'(22554);
   localparam logic signed [W-1:0] K_G_CR = W'(46802);
   localparam logic signed [W-1:0] K_B_CB = W'(116130);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e         state_q;
   logic [5:0]     idx_q;
   logic           drain_q;
   logic           busy_q;
   logic           done_q;

   logic [FPL-1:0] y_mem  [NPIX];
   logic [FPL-1:0] cb_mem [NPIX];
   logic [FPL-1:0] cr_mem [NPIX];

   logic           s1_vld_q;
   logic [5:0]     s1_idx_q;
   logic signed [W-1:0] s1_y_q;
   logic signed [W-1:0] s1_pr_q;
   logic signed [W-1:0] s1_pgb_q;
   logic signed [W-1:0] s1_pgr_q;
   logic signed [W-1:0] s1_pb_q;

   logic           s2_vld_q;
   logic [5:0]     s2_idx_q;
   logic signed [W-1:0] s2_r_q;
   logic signed [W-1:0] s2_g_q;
   logic signed [W-1:0] s2_b_q;

   logic [8*NPIX-1:0] r_q;
   logic [8*NPIX-1:0] g_q;
   logic [8*NPIX-1:0] b_q;

   logic accept_c;
   logic signed [W-1:0] y_iss_c;
   logic signed [W-1:0] dcb_iss_c;
   logic signed [W-1:0] dcr_iss_c;

   assign accept_c  = (state_q == ST_IDLE) && bus.start;

   // Issue-side operand select; chroma offset removed before the multiplies.
   assign y_iss_c   = W'($signed(y_mem[idx_q]));
   assign dcb_iss_c = W'($signed(cb_mem[idx_q])) - OFFSET;
   assign dcr_iss_c = W'($signed(cr_mem[idx_q])) - OFFSET;

   // Round half-up at the binary point, then saturate to an unsigned byte.
   function automatic logic [7:0] clamp8(input logic signed [W-1:0] v);
      logic signed [W-1:0] t;
      t = (v + HALF) >>> FRAC_BITS;
      if (t < 0) begin
         clamp8 = 8'd0;
      end else if (t > 255) begin
         clamp8 = 8'd255;
      end else begin
         clamp8 = 8'(t);
      end
   endfunction

   // Block sequencer: IDLE -> RUN (64 issues) -> DRAIN (2) -> DONE (1) -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 6'd0;
         drain_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q <= ST_RUN;
                  idx_q   <= 6'd0;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               idx_q <= idx_q + 6'd1;
               if (idx_q == 6'd63) begin
                  state_q <= ST_DRAIN;
                  drain_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               drain_q <= 1'b1;
               if (drain_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Sample capture on accept so the caller may change inputs afterwards.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         for (int i = 0; i < int'(NPIX); i++) begin
            y_mem[i]  <= bus.y_all[i*FPL +: FPL];
            cb_mem[i] <= bus.cb_all[i*FPL +: FPL];
            cr_mem[i] <= bus.cr_all[i*FPL +: FPL];
         end
      end
   end

   // S1 products and S2 rescaled sums; qualified downstream by the valid bits.
   always_ff @(posedge clk) begin
      s1_idx_q <= idx_q;
      s1_y_q   <= y_iss_c;
      s1_pr_q  <= dcr_iss_c * K_R_CR;
      s1_pgb_q <= dcb_iss_c * K_G_CB;
      s1_pgr_q <= dcr_iss_c * K_G_CR;
      s1_pb_q  <= dcb_iss_c * K_B_CB;

      s2_idx_q <= s1_idx_q;
      s2_r_q   <= s1_y_q + (s1_pr_q >>> KSHIFT);
      s2_g_q   <= s1_y_q - (s1_pgb_q >>> KSHIFT) - (s1_pgr_q >>> KSHIFT);
      s2_b_q   <= s1_y_q + (s1_pb_q >>> KSHIFT);
   end

   // Pipeline valids and S3 byte write-back into the output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
      end else begin
         s1_vld_q <= (state_q == ST_RUN);
         s2_vld_q <= s1_vld_q;
         if (s2_vld_q) begin
            r_q[{s2_idx_q, 3'b000} +: 8] <= clamp8(s2_r_q);
            g_q[{s2_idx_q, 3'b000} +: 8] <= clamp8(s2_g_q);
            b_q[{s2_idx_q, 3'b000} +: 8] <= clamp8(s2_b_q);
         end
      end
   end

   assign bus.r_all = r_q;
   assign bus.g_all = g_q;
   assign bus.b_all = b_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
